simple_alu: RTL and testbench



---
 rtl/simple_alu_pkg.sv | 17 +
 rtl/simple_alu_core.sv | 51 +++++
 rtl/simple_alu.sv | 45 ++++
 tb/tb_simple_alu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/simple_alu_pkg.sv
// Shared opcode encoding and default width for the simple ALU.
package simple_alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/simple_alu_core.sv
// Combinational ALU datapath: result and carry/borrow from a, b and opcode.
module simple_alu_core
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  // One extra bit catches the carry-out on add and the borrow on subtract.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];

  // Opcode decode; anything unlisted drives zero so no X reaches the register.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      OP_SLL: res = a << sh;
      OP_LSR: res = a >> sh;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_EQ:  res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/simple_alu.sv
// Registered ALU: core datapath, zero detect and a single output register stage.
module simple_alu
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] alu_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;
  logic             zero_nxt;

  simple_alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (a_i),
    .b     (b_i),
    .op    (alu_op_e'(op_i)),
    .res   (res_nxt),
    .carry (carry_nxt)
  );

  // Zero flag follows the next-state result, so EQ with unequal operands sets it.
  assign zero_nxt = (res_nxt == '0);

  // Output register; reset clears everything immediately, including zero_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_o   <= '0;
      carry_o <= 1'b0;
      zero_o  <= 1'b0;
    end else begin
      alu_o   <= res_nxt;
      carry_o <= carry_nxt;
      zero_o  <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_simple_alu.sv
// Scoreboard bench for simple_alu: directed plan vectors plus random vectors vs a reference model.
module tb_simple_alu;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [W-1:0] a_i, b_i;
  logic [2:0]   op_i;
  logic [W-1:0] alu_o;
  logic         carry_o, zero_o;

  typedef struct {
    logic [W-1:0] alu;
    logic         c;
    logic         z;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  simple_alu #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
    .alu_o   (alu_o),
    .carry_o (carry_o),
    .zero_o  (zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model from the arithmetic rules, using plain integers.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int r, c, sh;
    sh = b % W;
    c  = 0;
    case (op)
      0: begin r = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0; end
      1: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      2: r = (a * (1 << sh)) % MOD;
      3: r = a / (1 << sh);
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = (a == b) ? 1 : 0;
    endcase
    e.alu = r[W-1:0];
    e.c   = c[0];
    e.z   = (r == 0);
    e.a   = a[W-1:0];
    e.b   = b[W-1:0];
    e.op  = op[2:0];
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk_i);
    a_i  = a;
    b_i  = b;
    op_i = op;
  endtask

  // Directed vector with hand-derived expected values.
  task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input logic [W-1:0] ea, input logic ec, input logic ez);
    exp_t e;
    drive(a, b, op);
    e.alu = ea; e.c = ec; e.z = ez; e.a = a; e.b = b; e.op = op;
    q.push_back(e);
  endtask

  task automatic issue_rand();
    logic [W-1:0] a, b;
    logic [2:0]   op;
    a  = W'($urandom);
    b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    op = 3'($urandom);
    drive(a, b, op);
    q.push_back(model(int'(a), int'(b), int'(op)));
  endtask

  task automatic check_reset(input string tag);
    n_cmp++;
    if (alu_o !== '0 || carry_o !== 1'b0 || zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got alu=%h c=%b z=%b, want alu=00 c=0 z=0", tag, alu_o, carry_o, zero_o);
    end
  endtask

  // Monitor: each captured vector must show up right after the following edge.
  always @(posedge clk_i) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (alu_o !== e.alu || carry_o !== e.c || zero_o !== e.z) begin
        n_err++;
        $display("FAIL op%0d a=%h b=%h: got alu=%h c=%b z=%b, want alu=%h c=%b z=%b",
                 e.op, e.a, e.b, alu_o, carry_o, zero_o, e.alu, e.c, e.z);
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    a_i = 8'hA5; b_i = 8'h3C; op_i = 3'b000;
    // Reset holds outputs low across edges with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      a_i = W'($urandom); b_i = W'($urandom); op_i = 3'($urandom);
      check_reset("reset_hold");
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Shift / compare
    issue_exp(8'h50, 8'h58, 3'b011, 8'h50, 1'b0, 1'b0);
    issue_exp(8'h50, 8'h03, 3'b011, 8'h0A, 1'b0, 1'b0);
    issue_exp(8'h81, 8'h01, 3'b010, 8'h02, 1'b0, 1'b0);
    // Logic
    issue_exp(8'h58, 8'h78, 3'b100, 8'h58, 1'b0, 1'b0);
    issue_exp(8'h58, 8'h78, 3'b101, 8'h78, 1'b0, 1'b0);
    issue_exp(8'h58, 8'h78, 3'b110, 8'h20, 1'b0, 1'b0);
    // Equality
    issue_exp(8'h54, 8'h58, 3'b111, 8'h00, 1'b0, 1'b1);
    issue_exp(8'h54, 8'h54, 3'b111, 8'h01, 1'b0, 1'b0);
    // Arithmetic flags
    issue_exp(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1);
    issue_exp(8'h10, 8'h20, 3'b001, 8'hF0, 1'b1, 1'b0);
    issue_exp(8'h20, 8'h10, 3'b001, 8'h10, 1'b0, 1'b0);

    // Let the monitor consume the last vector, then reset between edges.
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge clk_i);
    check_reset("reset_after_edge");
    rst_ni = 1'b1;

    for (int i = 0; i < 1000; i++) issue_rand();

    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
